// File: rtl/coil_dwell_guard.sv
// coil_dwell_guard: forwards coil charge requests while enforcing max dwell, min rest and sync-loss cutoff
module coil_dwell_guard #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             ign_req,
  input  logic [CNT_W-1:0] max_dwell,
  input  logic [CNT_W-1:0] min_off,
  input  logic             fault_clr,
  output logic             coil_out,
  output logic             charging,
  output logic [CNT_W-1:0] last_dwell,
  output logic             fault_overdwell,
  output logic             fault_missed
);
  typedef enum logic [1:0] {IDLE, CHARGE, FORCED_OFF, REST} state_t;
  state_t state, state_n;
  logic req_q, rise, start, over_set, miss_set;
  logic [CNT_W-1:0] dwell_cnt, dwell_cnt_n, off_cnt, off_cnt_n;
  logic [CNT_W-1:0] lim_q, lim_q_n, off_q, off_q_n, last_dwell_n;
  assign rise = ign_req & ~req_q;
  assign start = rise & enable & (max_dwell != '0);
  assign coil_out = (state == CHARGE);
  assign charging = (state == CHARGE);
  always_comb begin
    state_n = state;
    dwell_cnt_n = dwell_cnt;
    off_cnt_n = off_cnt;
    lim_q_n = lim_q;
    off_q_n = off_q;
    last_dwell_n = last_dwell;
    over_set = 1'b0;
    miss_set = 1'b0;
    case (state)
      IDLE: begin
        miss_set = rise & ~start;
        if (start) begin
          state_n = CHARGE;
          dwell_cnt_n = CNT_W'(1);
          lim_q_n = max_dwell;
        end
      end
      CHARGE: begin
        if (!ign_req) state_n = REST;
        else if (!enable) state_n = FORCED_OFF;
        else if (dwell_cnt == lim_q) begin
          state_n = FORCED_OFF;
          over_set = 1'b1;
        end else dwell_cnt_n = dwell_cnt + CNT_W'(1);
      end
      FORCED_OFF: begin
        miss_set = rise;
        if (!ign_req) state_n = REST;
      end
      default: begin
        miss_set = rise;
        if (off_cnt >= off_q) state_n = IDLE;
        else off_cnt_n = off_cnt + CNT_W'(1);
      end
    endcase
    if (state == CHARGE && state_n != CHARGE) last_dwell_n = dwell_cnt;
    // every path into REST restarts the rest timer with a fresh min_off
    if (state_n == REST && state != REST) begin
      off_cnt_n = CNT_W'(1);
      off_q_n = min_off;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      req_q <= 1'b1;
      dwell_cnt <= '0;
      off_cnt <= '0;
      lim_q <= '0;
      off_q <= '0;
      last_dwell <= '0;
      fault_overdwell <= 1'b0;
      fault_missed <= 1'b0;
    end else begin
      state <= state_n;
      req_q <= ign_req;
      dwell_cnt <= dwell_cnt_n;
      off_cnt <= off_cnt_n;
      lim_q <= lim_q_n;
      off_q <= off_q_n;
      last_dwell <= last_dwell_n;
      fault_overdwell <= over_set | (fault_overdwell & ~fault_clr);
      fault_missed <= miss_set | (fault_missed & ~fault_clr);
    end
  end
endmodule

// File: tb/tb_coil_dwell_guard.sv
// tb_coil_dwell_guard: directed scenarios plus random traffic against a timestamp-style reference model
module tb_coil_dwell_guard;
  logic clk = 0, reset_n = 0, enable = 1, ign_req = 0, fault_clr = 0;
  logic [23:0] max_dwell = 24'd1000, min_off = 24'd50;
  logic coil_out, charging, fault_overdwell, fault_missed;
  logic [23:0] last_dwell;
  int checks = 0, failures = 0, hi = 0;
  bit m_prev, m_on, m_hold, m_fo, m_fm;
  int m_dwell, m_lim, m_rest, m_last;
  coil_dwell_guard #(.CNT_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ign_req(ign_req),
    .max_dwell(max_dwell), .min_off(min_off), .fault_clr(fault_clr),
    .coil_out(coil_out), .charging(charging), .last_dwell(last_dwell),
    .fault_overdwell(fault_overdwell), .fault_missed(fault_missed)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_prev = 1; m_on = 0; m_hold = 0; m_fo = 0; m_fm = 0;
    m_dwell = 0; m_lim = 0; m_rest = 0; m_last = 0;
  endtask
  task automatic model_step();
    bit rise, so, sm;
    rise = ign_req && !m_prev;
    so = 0; sm = 0;
    if (m_on) begin
      if (!ign_req) begin m_last = m_dwell; m_on = 0; m_rest = (min_off <= 1) ? 1 : int'(min_off); end
      else if (!enable) begin m_last = m_dwell; m_on = 0; m_hold = 1; end
      else if (m_dwell == m_lim) begin m_last = m_dwell; m_on = 0; m_hold = 1; so = 1; end
      else m_dwell++;
    end else if (m_hold) begin
      sm = rise;
      if (!ign_req) begin m_hold = 0; m_rest = (min_off <= 1) ? 1 : int'(min_off); end
    end else if (m_rest > 0) begin
      sm = rise;
      m_rest--;
    end else if (rise && enable && max_dwell != 0) begin
      m_on = 1; m_dwell = 1; m_lim = int'(max_dwell);
    end else sm = rise;
    m_fo = so || (m_fo && !fault_clr);
    m_fm = sm || (m_fm && !fault_clr);
    m_prev = ign_req;
  endtask
  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset(); else model_step();
    #1;
    if (coil_out) hi++;
    check("coil_out", coil_out, m_on);
    check("charging", charging, m_on);
    check("last_dwell", last_dwell, m_last);
    check("fault_overdwell", fault_overdwell, m_fo);
    check("fault_missed", fault_missed, m_fm);
  endtask
  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic clr_pulse();
    fault_clr = 1; tick(); fault_clr = 0;
  endtask
  initial begin
    model_reset();
    ticks(3);
    check("reset_coil", coil_out, 0);
    check("reset_last", last_dwell, 0);
    reset_n = 1;
    ticks(2);
    ign_req = 1; hi = 0; ticks(600);
    ign_req = 0; ticks(60);
    check("s1_high_cycles", hi, 600);
    check("s1_last", last_dwell, 600);
    check("s1_faults", {fault_overdwell, fault_missed}, 0);
    ign_req = 1; hi = 0; ticks(1500);
    check("s2_high_cycles", hi, 1000);
    check("s2_over", fault_overdwell, 1);
    check("s2_last", last_dwell, 1000);
    ign_req = 0; ticks(51);
    ign_req = 1; tick();
    check("s2_recharge", coil_out, 1);
    check("s2_no_miss", fault_missed, 0);
    clr_pulse();
    ticks(98);
    ign_req = 0; ticks(10);
    ign_req = 1; hi = 0; ticks(200);
    check("s3_no_charge", hi, 0);
    check("s3_missed", fault_missed, 1);
    ign_req = 0; ticks(60);
    clr_pulse();
    ign_req = 1; ticks(300);
    enable = 0; tick();
    check("s4_cut", coil_out, 0);
    check("s4_last", last_dwell, 300);
    check("s4_no_over", fault_overdwell, 0);
    enable = 1; hi = 0; ticks(100);
    check("s4_hold_off", hi, 0);
    ign_req = 0; ticks(51);
    ign_req = 1; tick();
    check("s4_recharge", coil_out, 1);
    ticks(199);
    reset_n = 0; model_reset(); #1;
    check("s5_async_coil", coil_out, 0);
    check("s5_async_chg", charging, 0);
    ticks(3);
    reset_n = 1; hi = 0; ticks(20);
    check("s5_no_charge", hi, 0);
    ign_req = 0; tick();
    ign_req = 1; tick();
    check("s5_resume", coil_out, 1);
    ign_req = 0; ticks(60);
    clr_pulse();
    max_dwell = 24'd20; ign_req = 1; hi = 0; ticks(20);
    fault_clr = 1; tick();
    check("s6_set_wins", fault_overdwell, 1);
    tick(); fault_clr = 0;
    check("s6_cleared", fault_overdwell, 0);
    check("s6_high_cycles", hi, 20);
    ign_req = 0; ticks(60);
    for (int s = 0; s < 800; s++) begin
      max_dwell = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom_range(1, 40));
      min_off = 24'($urandom_range(0, 20));
      enable = ($urandom_range(0, 7) != 0);
      ign_req = ~ign_req;
      fault_clr = ($urandom_range(0, 9) == 0);
      tick();
      fault_clr = 0;
      ticks($urandom_range(0, 29));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coil_dwell_guard.md
Name: coil_dwell_guard

Overview:
Downstream safety stage between the ignition output driver and the physical coil driver pin. It takes the raw per-cylinder ignition request and passes it to the coil. It also enforces these limits:
- Hard maximum dwell.
- Minimum coil rest time between charges.
- Coil turn-off when sync is lost.

It records the last dwell length and sets sticky fault flags. The top level reads these through the existing status path.

Parameters:
CNT_W, 24, width of dwell and rest counters and limit inputs (clock ticks)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  engine sync valid (from sync block); low forbids/aborts charging
ign_req  in  1  coil charge request from output driver (high = charge, falling edge = spark)
max_dwell  in  CNT_W  maximum coil-on time in clk ticks; 0 = channel disabled
min_off  in  CNT_W  minimum coil-off time after any coil turn-off, in clk ticks
fault_clr  in  1  single-cycle clear of sticky fault flags
coil_out  out  1  registered coil drive
charging  out  1  high while in CHARGE state
last_dwell  out  CNT_W  coil-on duration of last completed charge, in ticks
fault_overdwell  out  1  sticky: a charge was cut by max_dwell
fault_missed  out  1  sticky: a request rising edge was ignored (REST/FORCED_OFF/disabled)

Behaviour:
- Reset (async, immediate):
  - coil_out=0, charging=0, last_dwell=0, both faults=0.
  - state=IDLE, counters=0.
  - Request history register req_q=1, so a request already high when reset releases is NOT treated as an edge.
- req_q <= ign_req every cycle. rise = ign_req & ~req_q.
- States: IDLE, CHARGE, FORCED_OFF, REST. All outputs are registered.
- IDLE:
  - If rise & enable & max_dwell!=0: go to CHARGE; coil_out<=1; dwell_cnt<=1; latch max_dwell into lim_q.
  - Result: coil_out rises exactly 1 clk after ign_req is first sampled high.
  - rise with enable=0 or max_dwell=0: stay in IDLE; fault_missed<=1.
- CHARGE (priority top to bottom):
  - (a) ign_req==0 → REST; coil_out<=0; last_dwell<=dwell_cnt. This is a normal spark; coil_out falls 1 clk after ign_req.
  - (b) enable==0 → FORCED_OFF; coil_out<=0; last_dwell<=dwell_cnt; no fault.
  - (c) dwell_cnt==lim_q → FORCED_OFF; coil_out<=0; last_dwell<=dwell_cnt; fault_overdwell<=1.
  - (d) otherwise dwell_cnt<=dwell_cnt+1.
  - Coil is therefore high for at most lim_q cycles.
  - dwell_cnt cannot wrap, because lim_q ≤ 2^CNT_W−1.
- On any entry to REST: off_cnt<=1; latch min_off into off_q.
- FORCED_OFF: hold coil low until ign_req==0, then go to REST. Any rise in this state sets fault_missed.
- REST:
  - If off_cnt>=off_q, go to IDLE. min_off of 0 or 1 therefore gives 1 cycle of REST.
  - Otherwise off_cnt<=off_cnt+1.
  - A rise during REST is dropped: fault_missed<=1, and no charge occurs later from that request.
- charging = (state==CHARGE), registered alongside coil_out.
- Changes to max_dwell/min_off take effect only at the next CHARGE/REST entry.
- Fault flags:
  - Set only by the events above.
  - Cleared by fault_clr.
  - A set and a clear in the same cycle leave the flag set.
- last_dwell updates only on CHARGE exit and holds otherwise.

Test Plan:
1. max_dwell=1000, min_off=50, enable=1; ign_req high 600 cycles → coil_out rises 1 clk after req, is high exactly 600 cycles, last_dwell=600, no faults.
2. Same limits; ign_req held high 1500 cycles → coil_out high exactly 1000 cycles then low, fault_overdwell=1, last_dwell=1000. After req falls: 50 cycles REST, then a new rise charges normally.
3. After a spark, ign_req low 10 cycles then high for 200 cycles (inside 50-cycle REST) → coil_out stays low throughout, fault_missed=1.
4. enable dropped at dwell cycle 300 → coil_out low next clk, last_dwell=300, fault_overdwell=0. Re-charge only after req low, REST, then a new rise with enable=1.
5. reset_n pulsed low at dwell cycle 200 with ign_req still high → coil_out 0 immediately (async). After release with req still high there is no charge. Req low then high → charge resumes with 1-clk latency.
6. fault_clr asserted in the same cycle as an overdwell cut → fault_overdwell=1. fault_clr one cycle later → fault_overdwell=0.
